// File: rtl/adam_clk_div_ctrl_pkg.sv
// Shared types and sizing helpers for the divider-ratio sequencer.
//   state_e    : sequencer states
//   cnt_width(): phase-counter width for a given set of phase lengths
//   CNT_W      : phase-counter width for the default phase lengths
package adam_clk_div_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_GATE   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_ENABLE = 3'd5
    } state_e;

    // $clog2 of the longest phase, plus one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned drain,
                                              input int unsigned gate,
                                              input int unsigned settle);
        int unsigned m;
        m = drain;
        if (gate > m)   m = gate;
        if (settle > m) m = settle;
        return $clog2(m) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(64, 2, 2);

endpackage

// File: rtl/adam_clk_div_ctrl_timer.sv
// Loadable down-counter shared by the DRAIN, GATE and SETTLE phases.
//   clk, rst_n : clock, async active-low reset
//   load/value : load value into the counter (has priority over en)
//   en         : decrement by one, saturating at zero
//   zero       : counter currently holds zero
module adam_clk_div_ctrl_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/adam_clk_div_ctrl.sv
// Glitch-free reprogramming sequencer for an adam_clk_div divider.
// A request waits for the divider period boundary (or a drain timeout),
// gates the divided clock, loads the new ratio, lets it settle, then
// re-enables the clock and pulses done.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/req_ready  : request handshake, req_div = requested ratio
//   div_tick             : divider period-boundary pulse
//   div_o, div_load      : ratio to divider and its one-cycle load strobe
//   gate_en              : divided-clock enable (1 = running)
//   busy                 : reconfiguration in progress
//   done, timeout, err   : completion / drain-timeout / rejection pulses
module adam_clk_div_ctrl
    import adam_clk_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned RESET_DIV     = 1,
    parameter int unsigned GATE_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_div,
    input  logic             div_tick,
    output logic [WIDTH-1:0] div_o,
    output logic             div_load,
    output logic             gate_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err
);

    localparam int unsigned TMR_W = cnt_width(DRAIN_TIMEOUT, GATE_CYCLES, SETTLE_CYCLES);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [WIDTH-1:0]  new_div_q, new_div_d;
    logic              flag_q, flag_d;
    logic              load_q, load_d;
    logic              gate_q, gate_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              to_q, to_d;
    logic              err_q, err_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tmr_zero;

    // Each phase loads (length - 1) so that zero marks its final cycle.
    adam_clk_div_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_val),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        new_div_d = new_div_q;
        flag_d    = flag_q;
        load_d    = 1'b0;
        done_d    = 1'b0;
        to_d      = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    if (req_div == '0) begin
                        err_d = 1'b1;
                    end else if (req_div == div_q) begin
                        done_d = 1'b1;
                    end else begin
                        new_div_d = req_div;
                        flag_d    = 1'b0;
                        state_d   = ST_DRAIN;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(DRAIN_TIMEOUT - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (div_tick || tmr_zero) begin
                    flag_d   = !div_tick;
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GATE_CYCLES - 1);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GATE: begin
                if (tmr_zero) begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                    div_d   = new_div_q;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_ENABLE;
                    done_d  = 1'b1;
                    to_d    = flag_q;
                    flag_d  = 1'b0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_ENABLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gate_d  = !((state_d == ST_GATE) || (state_d == ST_LOAD) || (state_d == ST_SETTLE));
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= WIDTH'(RESET_DIV);
            new_div_q <= '0;
            flag_q    <= 1'b0;
            load_q    <= 1'b0;
            gate_q    <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            new_div_q <= new_div_d;
            flag_q    <= flag_d;
            load_q    <= load_d;
            gate_q    <= gate_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            to_q      <= to_d;
            err_q     <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign div_o     = div_q;
    assign div_load  = load_q;
    assign gate_en   = gate_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = to_q;
    assign err       = err_q;

endmodule

// File: tb/tb_adam_clk_div_ctrl.sv
// Scoreboard bench for adam_clk_div_ctrl: stimulus pushes expected
// responses and loads; a negedge monitor pops and compares them.
module tb_adam_clk_div_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RD    = 1;
    localparam int unsigned GC    = 2;
    localparam int unsigned SC    = 2;
    localparam int unsigned DT    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_div;
    logic             div_tick;
    logic [WIDTH-1:0] div_o;
    logic             div_load;
    logic             gate_en;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             err;

    adam_clk_div_ctrl #(
        .WIDTH         (WIDTH),
        .RESET_DIV     (RD),
        .GATE_CYCLES   (GC),
        .SETTLE_CYCLES (SC),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_div   (req_div),
        .div_tick  (div_tick),
        .div_o     (div_o),
        .div_load  (div_load),
        .gate_en   (gate_en),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        bit to;
        int div;
        int cyc;
    } resp_t;

    typedef struct {
        int div;
        int cyc;
    } ld_t;

    resp_t exp_q[$];
    ld_t   ld_q[$];
    resp_t mon_e;
    ld_t   mon_l;
    int    prev_div;
    int    cur_div;
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Handshake one request; d = cycle of div_tick after transfer (0 = never).
    task automatic send(input int div, input int d, output int t0);
        int    w;
        int    dd;
        resp_t r;
        ld_t   l;
        @(negedge clk);
        req_valid = 1'b1;
        req_div   = WIDTH'(div);
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("req_ready_wait", int'(req_ready), 1);
        t0 = cyc;
        if (div == 0) begin
            r = '{is_err: 1'b1, to: 1'b0, div: cur_div, cyc: t0 + 1};
            exp_q.push_back(r);
        end else if (div == cur_div) begin
            r = '{is_err: 1'b0, to: 1'b0, div: cur_div, cyc: t0 + 1};
            exp_q.push_back(r);
        end else begin
            dd = (d > 0 && d <= int'(DT)) ? d : int'(DT);
            l  = '{div: div, cyc: t0 + dd + int'(GC) + 1};
            ld_q.push_back(l);
            r  = '{is_err: 1'b0, to: !(d > 0 && d <= int'(DT)), div: div,
                   cyc: t0 + dd + int'(GC) + int'(SC) + 2};
            exp_q.push_back(r);
            cur_div = div;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (d > 0) begin
            repeat (d - 1) begin
                @(posedge clk);
                #1;
            end
            div_tick = 1'b1;
            @(posedge clk);
            #1 div_tick = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || ld_q.size() != 0 || !req_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("drain_queue", exp_q.size(), 0);
    endtask

    // Monitor: compares every response pulse and load against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'({done, err}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_err",     int'(err),     int'(mon_e.is_err));
                    chk("resp_done",    int'(done),    int'(!mon_e.is_err));
                    chk("resp_cycle",   cyc,           mon_e.cyc);
                    chk("resp_timeout", int'(timeout), int'(mon_e.to));
                    chk("resp_div",     int'(div_o),   mon_e.div);
                end
            end else if (timeout) begin
                chk("timeout_without_done", int'(timeout), 0);
            end
            if (div_load) begin
                chk("gate_during_load", int'(gate_en), 0);
                if (ld_q.size() == 0) begin
                    chk("unexpected_load", int'(div_load), 0);
                end else begin
                    mon_l = ld_q.pop_front();
                    chk("load_cycle", cyc,         mon_l.cyc);
                    chk("load_div",   int'(div_o), mon_l.div);
                end
            end else if (int'(div_o) != prev_div) begin
                chk("div_change_outside_load", int'(div_o), prev_div);
            end
        end
        prev_div = int'(div_o);
    end

    initial begin
        int t0;
        int ta;
        int tb;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_div   = '0;
        div_tick  = 1'b0;
        cur_div   = int'(RD);
        prev_div  = int'(RD);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values, then quiet idle (stray div_tick must be ignored).
        @(negedge clk);
        chk("rst_div_o",     int'(div_o),     int'(RD));
        chk("rst_gate_en",   int'(gate_en),   1);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_busy",      int'(busy),      0);
        div_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            div_tick = 1'b0;
            chk("idle_quiet", int'({div_load, done, timeout, err, busy, !gate_en}), 0);
        end

        // Normal change to 4 with tick in cycle 1.
        send(4, 1, t0);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            chk("norm_gate_en", int'(gate_en),   (k >= 2 && k <= 6) ? 0 : 1);
            chk("norm_busy",    int'(busy),      (k <= 7) ? 1 : 0);
            chk("norm_ready",   int'(req_ready), (k >= 8) ? 1 : 0);
        end
        wait_idle();

        // Drain timeout: no tick at all.
        send(7, 0, t0);
        wait_idle();
        chk("timeout_div_o", int'(div_o), 7);

        // Degenerate requests: zero ratio, then the current ratio.
        send(0, 0, t0);
        send(7, 0, t0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("degen_gate_en", int'(gate_en), 1);
            chk("degen_busy",    int'(busy),    0);
        end
        wait_idle();
        chk("degen_div_o", int'(div_o), 7);

        // Back-pressure: second request raised during SETTLE.
        send(9, 1, ta);
        while (cyc < ta + 5 && cyc < ta + 50) @(negedge clk);
        req_valid = 1'b1;
        req_div   = WIDTH'(2);
        chk("bp_ready_settle", int'(req_ready), 0);
        chk("bp_busy_settle",  int'(busy),      1);
        send(2, 1, tb);
        chk("bp_accept_cycle", tb, ta + 8);
        wait_idle();
        chk("bp_div_o", int'(div_o), 2);

        // Reset during GATE, then a fresh request.
        send(5, 1, t0);
        @(negedge clk);
        chk("mid_gate_low", int'(gate_en), 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        ld_q.delete();
        cur_div = int'(RD);
        #1;
        chk("mid_rst_gate_en", int'(gate_en),   1);
        chk("mid_rst_div_o",   int'(div_o),     int'(RD));
        chk("mid_rst_busy",    int'(busy),      0);
        chk("mid_rst_ready",   int'(req_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(3, 2, t0);
        wait_idle();
        chk("post_rst_div_o", int'(div_o), 3);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adam_clk_div_ctrl.md
Name: adam_clk_div_ctrl

Overview:
Sequencer that reprograms the division ratio of an adam_clk_div instance without glitches.
- Accepts a new ratio over a valid/ready request port.
- Waits for the divider period boundary, then gates the divided clock and loads the new ratio.
- Lets the divider settle, then re-enables the clock and reports completion.
- Sits beside each divider in the clock subsystem and is driven by the system control registers.

Parameters:
WIDTH, 8, bit width of the division ratio; matches the divider's WIDTH
RESET_DIV, 1, ratio driven on div_o out of reset; must be nonzero
GATE_CYCLES, 2, cycles the clock is held gated before the load; minimum 1
SETTLE_CYCLES, 2, cycles the clock stays gated after the load; minimum 1
DRAIN_TIMEOUT, 64, maximum cycles spent waiting for div_tick before forcing the change; minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  new-ratio request
req_ready  out  1  controller can accept a request
req_div  in  WIDTH  requested ratio
div_tick  in  1  divider finished a period (one-cycle pulse)
div_o  out  WIDTH  ratio driven to the divider
div_load  out  1  one-cycle pulse: divider latches div_o
gate_en  out  1  divided-clock enable (1 = clock runs)
busy  out  1  a reconfiguration is in progress
done  out  1  one-cycle pulse: request completed
timeout  out  1  one-cycle pulse with done: drain phase timed out
err  out  1  one-cycle pulse: request rejected

Behaviour:
Interface:
- One clock, clk. Reset rst_n is asynchronous and active-low.

Reset (applies immediately on assertion, including mid-operation):
- State IDLE, div_o=RESET_DIV, gate_en=1, req_ready=1.
- div_load=0, busy=0, done=0, timeout=0, err=0.
- Any in-flight change is abandoned; the divider is not loaded again.

Handshake:
- A transfer occurs when req_valid and req_ready are both 1 on a clk edge; req_div is captured on that edge.
- req_ready=1 only in IDLE.
- req_valid while not ready is ignored; the requester holds it.

States: IDLE, DRAIN, GATE, LOAD, SETTLE, ENABLE. One shared down-counter serves DRAIN, GATE and SETTLE. busy=1 in every state except IDLE.

Timing, with the transfer in cycle 0:
- IDLE, req_div==0: err=1 in cycle 1; stay IDLE; div_o unchanged.
- IDLE, req_div==div_o: done=1 in cycle 1; stay IDLE; no gating, no div_load.
- IDLE, otherwise: go to DRAIN; cycle 1 is the first DRAIN cycle.
- DRAIN: wait for div_tick, sampled from cycle 1.
  - Tick observed in cycle d: next state GATE.
  - No tick by the end of DRAIN cycle DRAIN_TIMEOUT: go to GATE and set the internal timeout flag.
  - div_tick outside DRAIN is ignored.
- GATE: gate_en=0 for GATE_CYCLES cycles (d+1 .. d+GATE_CYCLES).
- LOAD: exactly one cycle. div_load=1, div_o shows the new ratio from this cycle on, gate_en=0.
- SETTLE: gate_en=0 for SETTLE_CYCLES cycles.
- ENABLE: one cycle. gate_en=1, done=1, timeout=flag; flag cleared; next cycle IDLE with req_ready=1.

Latency:
- Transfer to done = d + GATE_CYCLES + SETTLE_CYCLES + 2 cycles.
- With defaults and d=1: done in cycle 7, req_ready back in cycle 8.

Invariants:
- gate_en=0 in every cycle where div_load=1.
- div_o changes only in a LOAD cycle or on reset.
- done, err and timeout are never high in IDLE except for the cycle-1 pulses above.

Decomposition:
Package adam_clk_div_ctrl_pkg holds:
- the state enum typedef;
- a localparam for the counter width, $clog2 of the maximum of DRAIN_TIMEOUT, GATE_CYCLES and SETTLE_CYCLES, plus 1.

Sub-module adam_clk_div_ctrl_timer: loadable down-counter.
- Inputs: load, value, en.
- Output: zero.
- Instantiated once and reused for the DRAIN, GATE and SETTLE phases.

Test Plan:
1. Reset then idle: after rst_n deassertion, div_o=1, gate_en=1, req_ready=1, busy=0; all pulses low for 20 cycles.
2. Normal change: defaults, request req_div=4, div_tick in cycle 1 -> gate_en low in cycles 2-6, div_load and div_o=4 in cycle 4, done in cycle 7, req_ready high in cycle 8.
3. Drain timeout: DRAIN_TIMEOUT=8, div_tick held low -> GATE entered after DRAIN cycle 8; done and timeout pulse together in cycle 14; div_o=new value.
4. Degenerate requests: req_div=0 -> err in cycle 1, no gating; req_div equal to div_o -> done in cycle 1, gate_en stays 1, div_load stays 0.
5. Back-pressure: second req_valid asserted during SETTLE -> req_ready=0 and no capture; it is accepted in the first IDLE cycle and completes with its own done.
6. Reset mid-operation: assert rst_n low during GATE -> gate_en=1, div_o=RESET_DIV and busy=0 asynchronously; after release a fresh request completes normally.
